// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - round-robin two-client arbiter/sequencer for the 8x4 lab stack
// Every accepted request occupies a fixed IDLE -> ISSUE -> SETTLE slot.
module stack_arbiter #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          a_push,
    input  logic          a_pop,
    input  logic [DW-1:0] a_data,
    input  logic          b_push,
    input  logic          b_pop,
    input  logic [DW-1:0] b_data,
    output logic          a_grant,
    output logic          b_grant,
    output logic          a_reject,
    output logic          b_reject,
    output logic          a_rvalid,
    output logic          b_rvalid,
    output logic [DW-1:0] rdata,
    output logic          stk_push,
    output logic          stk_pop,
    output logic [DW-1:0] stk_data_in,
    input  logic [DW-1:0] stk_data_out,
    input  logic          stk_full,
    input  logic          stk_empty
);

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last_b;
    logic          lat_b;
    logic          lat_rd;
    logic          a_req;
    logic          b_req;
    logic          sel_b;
    logic          sel_push;
    logic          sel_pop;
    logic [DW-1:0] sel_data;
    logic          illegal;
    logic          take;

    always_comb begin
        a_req     = a_push | a_pop;
        b_req     = b_push | b_pop;
        // B wins only when alone or when A was the last client served
        sel_b     = b_req & (~a_req | ~last_b);
        sel_push  = sel_b ? b_push : a_push;
        sel_pop   = sel_b ? b_pop  : a_pop;
        sel_data  = sel_b ? b_data : a_data;
        // pop and swap both need a valid top; a plain push needs room
        illegal   = sel_pop ? stk_empty : stk_full;
        take      = (state == IDLE) && (a_req || b_req);
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = ISSUE;
            ISSUE:   state_nxt = SETTLE;
            SETTLE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            a_grant     <= 1'b0;
            b_grant     <= 1'b0;
            a_reject    <= 1'b0;
            b_reject    <= 1'b0;
            a_rvalid    <= 1'b0;
            b_rvalid    <= 1'b0;
            rdata       <= '0;
            stk_push    <= 1'b0;
            stk_pop     <= 1'b0;
            stk_data_in <= '0;
            last_b      <= 1'b1;
            lat_b       <= 1'b0;
            lat_rd      <= 1'b0;
        end else begin
            a_grant  <= 1'b0;
            b_grant  <= 1'b0;
            a_reject <= 1'b0;
            b_reject <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            stk_push <= 1'b0;
            stk_pop  <= 1'b0;
            if (take) begin
                a_grant  <= ~sel_b;
                b_grant  <= sel_b;
                a_reject <= ~sel_b & illegal;
                b_reject <= sel_b & illegal;
                stk_push <= ~illegal & sel_push;
                stk_pop  <= ~illegal & sel_pop;
                if (!illegal) begin
                    stk_data_in <= sel_data;
                end
                last_b <= sel_b;
                lat_b  <= sel_b;
                lat_rd <= ~illegal & sel_pop;
            end
            if (state == SETTLE && lat_rd) begin
                rdata    <= stk_data_out;
                a_rvalid <= ~lat_b;
                b_rvalid <= lat_b;
            end
        end
    end

endmodule
